unidade_controle_multiciclo: RTL
================================

// Module: unidade_controle_multiciclo
// PURPOSE
//  Multicycle control FSM for the RISC-V datapath. Sequences fetch/decode/execute/memory/writeback.
//  Drives the immediate extender's fonte_imediato, ALU operand muxes, register file, PC, IR and memory.
//  Supports lh, sh, andi, srl, beq. Any other encoding is trapped as illegal.
//  Also provides a memory wait-timeout and a retired-instruction counter.
// PARAMETERS
//  LIMITE_ESPERA      255  max cycles waiting for mem_pronto before bus error (>=1)
//  LARGURA_CONTADOR   32   width of instr_concluidas
// PORTS
//  clk               in   1   single clock, rising edge
//  reset             in   1   synchronous, active-high
//  instrucao         in   32  IR contents (valid from DECODIFICA on)
//  zero              in   1   ALU zero flag, same cycle
//  mem_pronto        in   1   memory completes current request this cycle
//  mem_req           out  1   memory request active
//  mem_escreve       out  1   request is a write (only with mem_req)
//  escreve_ir        out  1   load IR and pc_antigo
//  escreve_pc        out  1   load PC
//  fonte_pc          out  1   0=ALU result, 1=ALUOut register
//  fonte_imediato    out  2   00=I, 01=S, 10=SB (to immediate extender)
//  alu_fonte_a       out  2   00=PC, 01=pc_antigo, 10=reg A
//  alu_fonte_b       out  2   00=reg B, 01=const 4, 10=imediato
//  alu_op            out  4   0000 ADD, 0001 SUB, 0010 AND, 0011 SRL
//  escreve_reg       out  1   register file write enable
//  mem_para_reg      out  1   writeback select: 1=memory data (half, sign-ext), 0=ALUOut
//  instrucao_ilegal  out  1   sticky, set in ILEGAL
//  erro_barramento   out  1   sticky, set on timeout
//  estado            out  4   current state (debug)
//  instr_concluidas  out  LARGURA_CONTADOR  retired-instruction count, wraps to 0
// BEHAVIOUR
//  Reset:
//   - While reset=1: all outputs 0, state<=BUSCA, counters 0, sticky flags cleared.
//   - Reset mid-operation abandons any request immediately; memory must tolerate this.
//  Output timing: Moore outputs decoded from state. Exceptions (Mealy): mem_pronto gating and beq escreve_pc=zero.
//  States (estado encoding):
//   0 BUSCA: mem_req=1, a=PC.
//     - On mem_pronto: escreve_ir=1, escreve_pc=1 (a=PC, b=4, ADD, fonte_pc=0) -> DECODIFICA.
//     - Otherwise hold.
//   1 DECODIFICA: a=pc_antigo, b=imediato, fonte_imediato=10, ADD (branch target into ALUOut).
//     - Next state: lh/sh->CALC_END, srl->EXEC_R, andi->EXEC_I, beq->DESVIO, else->ILEGAL.
//   2 CALC_END: a=A, b=imediato, ADD, fonte_imediato=00 (lh) or 01 (sh).
//     - Next: lh->LE_MEM, sh->ESCREVE_MEM.
//   3 LE_MEM: mem_req=1; on mem_pronto -> ESCREVE_LH.
//   4 ESCREVE_LH: escreve_reg=1, mem_para_reg=1 -> BUSCA.
//   5 ESCREVE_MEM: mem_req=1, mem_escreve=1; on mem_pronto -> BUSCA.
//   6 EXEC_R: a=A, b=B, SRL (shift amount = B[4:0]) -> ESCREVE_ULA.
//   7 EXEC_I: a=A, b=imediato, fonte_imediato=00, AND -> ESCREVE_ULA.
//   8 ESCREVE_ULA: escreve_reg=1, mem_para_reg=0 -> BUSCA.
//   9 DESVIO: a=A, b=B, SUB, fonte_pc=1, escreve_pc=zero -> BUSCA.
//   10 ILEGAL: instrucao_ilegal=1; absorbing until reset.
//   11 ERRO_BARRAMENTO: erro_barramento=1; absorbing until reset.
//  Decode match rules:
//   - lh: opcode 0000011, f3=001.  sh: 0100011, f3=001.  andi: 0010011, f3=111.
//   - srl: 0110011, f3=101, f7=0000000.  beq: 1100011, f3=000.
//  Timeout:
//   - Wait counter clears on entry to BUSCA/LE_MEM/ESCREVE_MEM; increments each cycle without mem_pronto.
//   - When it reaches LIMITE_ESPERA -> ERRO_BARRAMENTO.
//   - mem_pronto in the terminal-count cycle wins (normal completion).
//  Counting: instr_concluidas +1 on the last cycle of each instruction (ESCREVE_LH; ESCREVE_MEM with pronto; ESCREVE_ULA; DESVIO).
//  CPI with zero-wait memory: lh 5, sh 4, andi/srl 4, beq 3.
// STRUCTURE
//  Package controle_defs: state encodings, opcode/funct3/funct7 constants, alu_op codes, mux select codes.
//  fonte_imediato codes live in the same package; the immediate extender uses the identical encoding.
//  Sub-module decodificador_instrucao: combinational instrucao -> {eh_lh, eh_sh, eh_andi, eh_srl, eh_beq, ilegal}.
// TESTING
//  1. andi x1,x0,7 (0x00707093), pronto every cycle:
//     - BUSCA,DECODIFICA,EXEC_I,ESCREVE_ULA; escreve_reg=1 on cycle 4; fonte_imediato=00 in EXEC_I; count=1.
//  2. lh x2,4(x0) (0x00401103), pronto delayed 3 cycles in LE_MEM:
//     - 8 cycles total; mem_escreve=0 throughout; mem_para_reg=1 in ESCREVE_LH.
//  3. sh x1,4(x0) (0x00101223):
//     - fonte_imediato=01 in CALC_END; mem_req=1 & mem_escreve=1 in ESCREVE_MEM; escreve_reg never 1.
//  4. beq x6,x1,+8 (0x00130463):
//     - zero=1 -> escreve_pc=1, fonte_pc=1 in DESVIO; zero=0 -> escreve_pc=0; both retire in 3 cycles.
//  5. srl x3,x1,x2 (0x0020D1B3) -> alu_op=0011 in EXEC_R.
//     - 0xFFFFFFFF -> ILEGAL, instrucao_ilegal=1 held 10+ cycles until reset.
//  6. LIMITE_ESPERA=4, mem_pronto held 0 in BUSCA -> ERRO_BARRAMENTO after 4 cycles.
//     - pronto on exactly the 4th cycle -> DECODIFICA.
//     - reset asserted mid-LE_MEM -> outputs 0 next edge; BUSCA, count 0.

Source files
------------

// File: rtl/controle_defs_pkg.sv
// rtl/controle_defs_pkg.sv - shared encodings for the multicycle control unit
// States, decode fields, ALU operations and datapath mux selects.
package controle_defs;

  typedef enum logic [3:0] {
    BUSCA           = 4'd0,
    DECODIFICA      = 4'd1,
    CALC_END        = 4'd2,
    LE_MEM          = 4'd3,
    ESCREVE_LH      = 4'd4,
    ESCREVE_MEM     = 4'd5,
    EXEC_R          = 4'd6,
    EXEC_I          = 4'd7,
    ESCREVE_ULA     = 4'd8,
    DESVIO          = 4'd9,
    ILEGAL          = 4'd10,
    ERRO_BARRAMENTO = 4'd11
  } estado_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_ANDI = 3'b111;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [6:0] F7_SRL  = 7'b0000000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_SRL = 4'b0011;

  localparam logic [1:0] FONTE_A_PC        = 2'b00;
  localparam logic [1:0] FONTE_A_PC_ANTIGO = 2'b01;
  localparam logic [1:0] FONTE_A_REG       = 2'b10;

  localparam logic [1:0] FONTE_B_REG    = 2'b00;
  localparam logic [1:0] FONTE_B_QUATRO = 2'b01;
  localparam logic [1:0] FONTE_B_IMED   = 2'b10;

  // Shared with the immediate extender; both sides must agree on these codes.
  localparam logic [1:0] IMED_I  = 2'b00;
  localparam logic [1:0] IMED_S  = 2'b01;
  localparam logic [1:0] IMED_SB = 2'b10;

endpackage

// File: rtl/decodificador_instrucao.sv
// rtl/decodificador_instrucao.sv - combinational instruction classifier
// Flags the five supported encodings; anything else is ilegal.
module decodificador_instrucao
  import controle_defs::*;
(
  input  logic [31:0] instrucao,
  output logic        eh_lh,
  output logic        eh_sh,
  output logic        eh_andi,
  output logic        eh_srl,
  output logic        eh_beq,
  output logic        ilegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_unused_campos;

  assign w_opcode = instrucao[6:0];
  assign w_funct3 = instrucao[14:12];
  assign w_funct7 = instrucao[31:25];
  // Register and immediate fields do not influence control.
  assign w_unused_campos = ^{instrucao[24:15], instrucao[11:7]};

  assign eh_lh   = (w_opcode == OP_LOAD)   && (w_funct3 == F3_LH);
  assign eh_sh   = (w_opcode == OP_STORE)  && (w_funct3 == F3_SH);
  assign eh_andi = (w_opcode == OP_IMM)    && (w_funct3 == F3_ANDI);
  assign eh_srl  = (w_opcode == OP_REG)    && (w_funct3 == F3_SRL) && (w_funct7 == F7_SRL);
  assign eh_beq  = (w_opcode == OP_BRANCH) && (w_funct3 == F3_BEQ);
  assign ilegal  = !(eh_lh || eh_sh || eh_andi || eh_srl || eh_beq);

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// rtl/unidade_controle_multiciclo.sv - multicycle RISC-V control FSM
// Sequences fetch/decode/execute/memory/writeback with memory timeout and retire count.
module unidade_controle_multiciclo
  import controle_defs::*;
#(
  parameter int LIMITE_ESPERA    = 255,
  parameter int LARGURA_CONTADOR = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 instrucao,
  input  logic                        zero,
  input  logic                        mem_pronto,
  output logic                        mem_req,
  output logic                        mem_escreve,
  output logic                        escreve_ir,
  output logic                        escreve_pc,
  output logic                        fonte_pc,
  output logic [1:0]                  fonte_imediato,
  output logic [1:0]                  alu_fonte_a,
  output logic [1:0]                  alu_fonte_b,
  output logic [3:0]                  alu_op,
  output logic                        escreve_reg,
  output logic                        mem_para_reg,
  output logic                        instrucao_ilegal,
  output logic                        erro_barramento,
  output logic [3:0]                  estado,
  output logic [LARGURA_CONTADOR-1:0] instr_concluidas
);

  localparam int LARGURA_ESPERA = $clog2(LIMITE_ESPERA + 1);
  localparam logic [LARGURA_ESPERA-1:0] ULTIMA_ESPERA = LARGURA_ESPERA'(LIMITE_ESPERA - 1);

  estado_t                     r_estado;
  estado_t                     w_proximo;
  logic [LARGURA_ESPERA-1:0]   r_espera;
  logic [LARGURA_CONTADOR-1:0] r_concluidas;
  logic                        r_ilegal;
  logic                        r_erro;

  logic w_eh_lh, w_eh_sh, w_eh_andi, w_eh_srl, w_eh_beq, w_ilegal;
  logic w_aguarda, w_estouro, w_retira;

  decodificador_instrucao u_decodificador (
    .instrucao (instrucao),
    .eh_lh     (w_eh_lh),
    .eh_sh     (w_eh_sh),
    .eh_andi   (w_eh_andi),
    .eh_srl    (w_eh_srl),
    .eh_beq    (w_eh_beq),
    .ilegal    (w_ilegal)
  );

  assign w_aguarda = (r_estado == BUSCA) || (r_estado == LE_MEM) || (r_estado == ESCREVE_MEM);
  // Completion in the terminal-count cycle takes priority over the timeout.
  assign w_estouro = w_aguarda && !mem_pronto && (r_espera == ULTIMA_ESPERA);
  assign w_retira  = (r_estado == ESCREVE_LH) || (r_estado == ESCREVE_ULA) ||
                     (r_estado == DESVIO) || ((r_estado == ESCREVE_MEM) && mem_pronto);

  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      BUSCA:       w_proximo = mem_pronto ? DECODIFICA : (w_estouro ? ERRO_BARRAMENTO : BUSCA);
      DECODIFICA: begin
        if (w_ilegal)                 w_proximo = ILEGAL;
        else if (w_eh_lh || w_eh_sh)  w_proximo = CALC_END;
        else if (w_eh_srl)            w_proximo = EXEC_R;
        else if (w_eh_andi)           w_proximo = EXEC_I;
        else                          w_proximo = DESVIO;
      end
      CALC_END:    w_proximo = w_eh_lh ? LE_MEM : (w_eh_sh ? ESCREVE_MEM : ILEGAL);
      LE_MEM:      w_proximo = mem_pronto ? ESCREVE_LH : (w_estouro ? ERRO_BARRAMENTO : LE_MEM);
      ESCREVE_MEM: w_proximo = mem_pronto ? BUSCA : (w_estouro ? ERRO_BARRAMENTO : ESCREVE_MEM);
      ESCREVE_LH, ESCREVE_ULA, DESVIO: w_proximo = BUSCA;
      EXEC_R, EXEC_I:  w_proximo = ESCREVE_ULA;
      ILEGAL:          w_proximo = ILEGAL;
      ERRO_BARRAMENTO: w_proximo = ERRO_BARRAMENTO;
      default:         w_proximo = ILEGAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado     <= BUSCA;
      r_espera     <= '0;
      r_concluidas <= '0;
      r_ilegal     <= 1'b0;
      r_erro       <= 1'b0;
    end else begin
      r_estado <= w_proximo;
      if (w_proximo != r_estado)
        r_espera <= '0;
      else if (w_aguarda && !mem_pronto)
        r_espera <= r_espera + 1'b1;
      if (w_retira)
        r_concluidas <= r_concluidas + 1'b1;
      if (w_proximo == ILEGAL)
        r_ilegal <= 1'b1;
      if (w_proximo == ERRO_BARRAMENTO)
        r_erro <= 1'b1;
    end
  end

  always_comb begin
    mem_req          = 1'b0;
    mem_escreve      = 1'b0;
    escreve_ir       = 1'b0;
    escreve_pc       = 1'b0;
    fonte_pc         = 1'b0;
    fonte_imediato   = IMED_I;
    alu_fonte_a      = FONTE_A_PC;
    alu_fonte_b      = FONTE_B_REG;
    alu_op           = ALU_ADD;
    escreve_reg      = 1'b0;
    mem_para_reg     = 1'b0;
    instrucao_ilegal = r_ilegal;
    erro_barramento  = r_erro;
    estado           = r_estado;
    instr_concluidas = r_concluidas;
    case (r_estado)
      BUSCA: begin
        mem_req     = 1'b1;
        escreve_ir  = mem_pronto;
        escreve_pc  = mem_pronto;
        alu_fonte_b = FONTE_B_QUATRO;
      end
      DECODIFICA: begin
        fonte_imediato = IMED_SB;
        alu_fonte_a    = FONTE_A_PC_ANTIGO;
        alu_fonte_b    = FONTE_B_IMED;
      end
      CALC_END: begin
        fonte_imediato = w_eh_sh ? IMED_S : IMED_I;
        alu_fonte_a    = FONTE_A_REG;
        alu_fonte_b    = FONTE_B_IMED;
      end
      LE_MEM:      mem_req = 1'b1;
      ESCREVE_LH: begin
        escreve_reg  = 1'b1;
        mem_para_reg = 1'b1;
      end
      ESCREVE_MEM: begin
        mem_req     = 1'b1;
        mem_escreve = 1'b1;
      end
      EXEC_R: begin
        alu_fonte_a = FONTE_A_REG;
        alu_op      = ALU_SRL;
      end
      EXEC_I: begin
        alu_fonte_a = FONTE_A_REG;
        alu_fonte_b = FONTE_B_IMED;
        alu_op      = ALU_AND;
      end
      ESCREVE_ULA: escreve_reg = 1'b1;
      DESVIO: begin
        alu_fonte_a = FONTE_A_REG;
        alu_op      = ALU_SUB;
        fonte_pc    = 1'b1;
        escreve_pc  = zero;
      end
      default: ;
    endcase
    // Outputs are forced low for as long as reset is held.
    if (reset) begin
      mem_req          = 1'b0;
      mem_escreve      = 1'b0;
      escreve_ir       = 1'b0;
      escreve_pc       = 1'b0;
      fonte_pc         = 1'b0;
      fonte_imediato   = 2'b00;
      alu_fonte_a      = 2'b00;
      alu_fonte_b      = 2'b00;
      alu_op           = 4'b0000;
      escreve_reg      = 1'b0;
      mem_para_reg     = 1'b0;
      instrucao_ilegal = 1'b0;
      erro_barramento  = 1'b0;
      estado           = 4'd0;
      instr_concluidas = '0;
    end
  end

endmodule
